alufpu_issue: RTL and testbench

Operand issue sequencer on the initiator side of the `alufpu` interface. Accepts ALU/FPU operation requests over a valid/ready handshake and buffers them in a small FIFO. Issues one operation at a time by driving registered `busA`/`busB`/`ALUctrl` or `fbusA`/`fbusB`/`FPUctrl` into `alufpu`, samples `ALUout`/`FPUout`/`branch` one cycle later, and returns the result over a second valid/ready handshake. Sits between decode/register-read and the `alufpu` instance.

---
 rtl/alufpu_pkg.sv | 29 ++
 rtl/alufpu_issue_if.sv | 57 +++++
 rtl/alufpu_issue_fifo.sv | 78 +++++++
 rtl/alufpu_issue.sv | 193 +++++++++++++++++++
 tb/tb_alufpu_issue.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alufpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alufpu_pkg
// Description : Shared types and widths for the alufpu operand issue
//               sequencer: FSM state encoding, bus widths and the request
//               record buffered in the request FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package alufpu_pkg;

  localparam int DATA_W    = 32;
  localparam int ALUCTRL_W = 4;
  localparam int STAT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic                 fpu;
    logic [ALUCTRL_W-1:0] ctrl;
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
  } req_t;

endpackage
`default_nettype wire

// File: rtl/alufpu_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : alufpu_issue_if
// Description : Bundles the request handshake, the alufpu operand/result
//               buses and the response handshake of the issue sequencer.
//   slave  : sequencer side (takes requests, drives alufpu, returns results)
//   master : environment side (decode/register-read, alufpu, consumer)
// Revision    : 1.0 - initial release
// ============================================================================
interface alufpu_issue_if;
  import alufpu_pkg::*;

  // request handshake
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_fpu;
  logic [ALUCTRL_W-1:0] req_ctrl;
  logic [DATA_W-1:0]    req_a;
  logic [DATA_W-1:0]    req_b;
  // alufpu operand buses
  logic [DATA_W-1:0]    busA;
  logic [DATA_W-1:0]    busB;
  logic [ALUCTRL_W-1:0] ALUctrl;
  logic [DATA_W-1:0]    fbusA;
  logic [DATA_W-1:0]    fbusB;
  logic                 FPUctrl;
  // alufpu results
  logic [DATA_W-1:0]    ALUout;
  logic [DATA_W-1:0]    FPUout;
  logic                 branch;
  // response handshake
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_W-1:0]    rsp_data;
  logic                 rsp_branch;
  logic                 rsp_fpu;

  modport slave (
    input  req_valid, req_fpu, req_ctrl, req_a, req_b,
    output req_ready,
    output busA, busB, ALUctrl, fbusA, fbusB, FPUctrl,
    input  ALUout, FPUout, branch,
    output rsp_valid, rsp_data, rsp_branch, rsp_fpu,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_fpu, req_ctrl, req_a, req_b,
    input  req_ready,
    input  busA, busB, ALUctrl, fbusA, fbusB, FPUctrl,
    output ALUout, FPUout, branch,
    input  rsp_valid, rsp_data, rsp_branch, rsp_fpu,
    output rsp_ready
  );

endinterface
`default_nettype wire

// File: rtl/alufpu_issue_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alufpu_issue_fifo
// Description : Synchronous FIFO with registered occupancy count and a
//               combinational head read.
//   clk, rst       : clock, synchronous active-high reset
//   push, wr_data  : write request (ignored when full)
//   pop, rd_data   : read request (ignored when empty), head entry
//   full, empty    : status derived from the registered count
//   count          : occupancy, log2(DEPTH)+1 bits
// Revision    : 1.0 - initial release
// ============================================================================
module alufpu_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop frees a slot in the same
  // cycle, keeping the upstream ready a pure function of the count flops.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/alufpu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alufpu_issue
// Description : Operand issue sequencer in front of a combinational alufpu.
//               Buffers ALU/FPU requests, drives one operation at a time on
//               registered operand buses, captures the result one cycle
//               later and returns it over a valid/ready handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alufpu_issue_if.slave (request, alufpu buses, response)
//   op_count_alu / op_count_fpu : saturating issue counters, present only
//              when ALUFPU_ISSUE_STATS_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module alufpu_issue
  import alufpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  alufpu_issue_if.slave bus
`ifdef ALUFPU_ISSUE_STATS_EN
  ,
  output logic [STAT_W-1:0] op_count_alu,
  output logic [STAT_W-1:0] op_count_fpu
`endif
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  req_t             wr_req, head;
  logic             fifo_full, fifo_empty, pop_go;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_fifo_count;

  state_e               state_q, state_d;
  logic                 fpu_op_q, fpu_op_d;
  logic [DATA_W-1:0]    bus_a_q, bus_a_d, bus_b_q, bus_b_d;
  logic [ALUCTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [DATA_W-1:0]    fbus_a_q, fbus_a_d, fbus_b_q, fbus_b_d;
  logic                 fpu_ctrl_q, fpu_ctrl_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_branch_q, rsp_branch_d;
  logic                 rsp_fpu_q, rsp_fpu_d;

  always_comb begin
    wr_req      = '0;
    wr_req.fpu  = bus.req_fpu;
    wr_req.ctrl = bus.req_ctrl;
    wr_req.a    = bus.req_a;
    wr_req.b    = bus.req_b;
  end

  alufpu_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(req_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.req_valid),
    .wr_data (wr_req),
    .pop     (pop_go),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Occupancy is a debug view only; the sequencer needs just full/empty.
  assign unused_fifo_count = ^fifo_count;

  assign bus.req_ready = !fifo_full;

  // The RESP handshake edge pops the next op straight into ISSUE, which is
  // what gives one op per two cycles under continuous rsp_ready.
  assign pop_go = !fifo_empty &&
                  ((state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready));

  always_comb begin
    state_d      = state_q;
    fpu_op_d     = fpu_op_q;
    bus_a_d      = bus_a_q;
    bus_b_d      = bus_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    fbus_a_d     = fbus_a_q;
    fbus_b_d     = fbus_b_q;
    fpu_ctrl_d   = fpu_ctrl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_branch_d = rsp_branch_q;
    rsp_fpu_d    = rsp_fpu_q;

    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_ISSUE: begin
        // alufpu has settled for a full cycle on the held buses
        rsp_valid_d  = 1'b1;
        rsp_data_d   = fpu_op_q ? bus.FPUout : bus.ALUout;
        rsp_branch_d = fpu_op_q ? 1'b0 : bus.branch;
        rsp_fpu_d    = fpu_op_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The idle side of the bus pair is zeroed so only one unit sees operands.
    if (pop_go) begin
      state_d    = ST_ISSUE;
      fpu_op_d   = head.fpu;
      bus_a_d    = head.fpu ? '0 : head.a;
      bus_b_d    = head.fpu ? '0 : head.b;
      alu_ctrl_d = head.fpu ? '0 : head.ctrl;
      fbus_a_d   = head.fpu ? head.a : '0;
      fbus_b_d   = head.fpu ? head.b : '0;
      fpu_ctrl_d = head.fpu ? head.ctrl[0] : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fpu_op_q     <= 1'b0;
      bus_a_q      <= '0;
      bus_b_q      <= '0;
      alu_ctrl_q   <= '0;
      fbus_a_q     <= '0;
      fbus_b_q     <= '0;
      fpu_ctrl_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_branch_q <= 1'b0;
      rsp_fpu_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fpu_op_q     <= fpu_op_d;
      bus_a_q      <= bus_a_d;
      bus_b_q      <= bus_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      fbus_a_q     <= fbus_a_d;
      fbus_b_q     <= fbus_b_d;
      fpu_ctrl_q   <= fpu_ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_branch_q <= rsp_branch_d;
      rsp_fpu_q    <= rsp_fpu_d;
    end
  end

  assign bus.busA       = bus_a_q;
  assign bus.busB       = bus_b_q;
  assign bus.ALUctrl    = alu_ctrl_q;
  assign bus.fbusA      = fbus_a_q;
  assign bus.fbusB      = fbus_b_q;
  assign bus.FPUctrl    = fpu_ctrl_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_branch = rsp_branch_q;
  assign bus.rsp_fpu    = rsp_fpu_q;

`ifdef ALUFPU_ISSUE_STATS_EN
  logic [STAT_W-1:0] alu_cnt_q, alu_cnt_d;
  logic [STAT_W-1:0] fpu_cnt_q, fpu_cnt_d;

  // Counted on entry to ISSUE, i.e. on every pop; both saturate.
  always_comb begin
    alu_cnt_d = alu_cnt_q;
    fpu_cnt_d = fpu_cnt_q;
    if (pop_go && !head.fpu && (alu_cnt_q != '1)) alu_cnt_d = alu_cnt_q + STAT_W'(1);
    if (pop_go &&  head.fpu && (fpu_cnt_q != '1)) fpu_cnt_d = fpu_cnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_cnt_q <= '0;
      fpu_cnt_q <= '0;
    end else begin
      alu_cnt_q <= alu_cnt_d;
      fpu_cnt_q <= fpu_cnt_d;
    end
  end

  assign op_count_alu = alu_cnt_q;
  assign op_count_fpu = fpu_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alufpu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alufpu_issue
// Description : Self-checking bench for alufpu_issue. A behavioural alufpu
//               stub closes the loop; an ordered queue of issued requests
//               predicts every response and the operand buses behind it.
//               Define ALUFPU_ISSUE_STATS_EN to also check the op counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alufpu_issue;

  typedef struct {
    bit       fpu;
    bit [3:0] ctrl;
    bit [31:0] a;
    bit [31:0] b;
  } op_t;

  logic clk;
  logic rst;

  alufpu_issue_if bus_if();

`ifdef ALUFPU_ISSUE_STATS_EN
  logic [15:0] op_count_alu;
  logic [15:0] op_count_fpu;
`endif

  alufpu_issue #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
`ifdef ALUFPU_ISSUE_STATS_EN
    ,
    .op_count_alu (op_count_alu),
    .op_count_fpu (op_count_fpu)
`endif
  );

  // Behavioural alufpu stub
  assign bus_if.ALUout = bus_if.busA + bus_if.busB;
  assign bus_if.branch = (bus_if.busA == bus_if.busB);
  assign bus_if.FPUout = bus_if.fbusA ^ bus_if.fbusB;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  op_t  model_q[$];
  int   rsp_total = 0;
  int   exp_alu = 0;
  int   exp_fpu = 0;
  bit   chk_gap = 0;
  bit   have_prev = 0;
  int   prev_rsp_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk_op(input bit fpu, input bit [3:0] ctrl, input bit [31:0] a, input bit [31:0] b);
    op_t o;
    o.fpu = fpu; o.ctrl = ctrl; o.a = a; o.b = b;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.fpu  = 1'($urandom_range(0, 1));
    o.ctrl = 4'($urandom_range(0, 15));
    o.a    = $urandom;
    o.b    = ($urandom_range(0, 3) == 0) ? o.a : $urandom;
    return o;
  endfunction

  // Expected alufpu result for an operation, from the stub's arithmetic.
  function automatic logic [31:0] exp_data(input op_t o);
    return o.fpu ? (o.a ^ o.b) : (o.a + o.b);
  endfunction

  function automatic logic exp_branch(input op_t o);
    return o.fpu ? 1'b0 : (o.a == o.b);
  endfunction

  task automatic drive_req(input op_t o);
    bus_if.req_fpu  = o.fpu;
    bus_if.req_ctrl = o.ctrl;
    bus_if.req_a    = o.a;
    bus_if.req_b    = o.b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_bus(input op_t o);
    chk("busA",    bus_if.busA,  o.fpu ? 32'd0 : o.a);
    chk("busB",    bus_if.busB,  o.fpu ? 32'd0 : o.b);
    chk("ALUctrl", 32'(bus_if.ALUctrl), o.fpu ? 32'd0 : 32'(o.ctrl));
    chk("fbusA",   bus_if.fbusA, o.fpu ? o.a : 32'd0);
    chk("fbusB",   bus_if.fbusB, o.fpu ? o.b : 32'd0);
    chk("FPUctrl", 32'(bus_if.FPUctrl), o.fpu ? 32'(o.ctrl[0]) : 32'd0);
  endtask

  task automatic check_rsp(input op_t o);
    chk("rsp_data",   bus_if.rsp_data, exp_data(o));
    chk("rsp_branch", 32'(bus_if.rsp_branch), 32'(exp_branch(o)));
    chk("rsp_fpu",    32'(bus_if.rsp_fpu), 32'(o.fpu));
    check_bus(o);
  endtask

  task automatic chk_stats();
`ifdef ALUFPU_ISSUE_STATS_EN
    chk("op_count_alu", 32'(op_count_alu), 32'(exp_alu));
    chk("op_count_fpu", 32'(op_count_fpu), 32'(exp_fpu));
`endif
  endtask

  // One clock: score any handshake that the coming edge completes.
  task automatic step();
    bit  do_push, do_rsp;
    op_t e, cur;
    do_push = bus_if.req_valid && bus_if.req_ready;
    do_rsp  = bus_if.rsp_valid && bus_if.rsp_ready;
    if (do_rsp) begin
      if (model_q.size() == 0) begin
        chk("spurious_rsp", 32'(bus_if.rsp_valid), 32'd0);
      end else begin
        e = model_q.pop_front();
        check_rsp(e);
        rsp_total++;
        if (e.fpu) exp_fpu++; else exp_alu++;
        if (chk_gap && have_prev) chk("rsp_gap", 32'(cyc - prev_rsp_cyc), 32'd2);
        have_prev    = 1'b1;
        prev_rsp_cyc = cyc;
      end
    end
    if (do_push) begin
      cur = mk_op(bus_if.req_fpu, bus_if.req_ctrl, bus_if.req_a, bus_if.req_b);
      model_q.push_back(cur);
    end
    tick();
    if (do_push) bus_if.req_valid = 1'b0;
  endtask

  // Single op into an idle block with rsp_ready high; checks exact latency.
  task automatic run_one(input op_t o);
    drive_req(o);
    bus_if.req_valid = 1'b1;
    chk("accept_ready", 32'(bus_if.req_ready), 32'd1);
    tick();                                  // E0: accepted
    bus_if.req_valid = 1'b0;
    chk("lat_e0_valid", 32'(bus_if.rsp_valid), 32'd0);
    tick();                                  // E1: buses driven
    chk("lat_e1_valid", 32'(bus_if.rsp_valid), 32'd0);
    check_bus(o);
    tick();                                  // E2: result registered
    chk("lat_e2_valid", 32'(bus_if.rsp_valid), 32'd1);
    check_rsp(o);
    tick();                                  // E3: handshake
    chk("lat_e3_valid", 32'(bus_if.rsp_valid), 32'd0);
    rsp_total++;
    if (o.fpu) exp_fpu++; else exp_alu++;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rsp_valid"},  32'(bus_if.rsp_valid), 32'd0);
    chk({tag, "_rsp_data"},   bus_if.rsp_data, 32'd0);
    chk({tag, "_rsp_branch"}, 32'(bus_if.rsp_branch), 32'd0);
    chk({tag, "_rsp_fpu"},    32'(bus_if.rsp_fpu), 32'd0);
    chk({tag, "_req_ready"},  32'(bus_if.req_ready), 32'd1);
    check_bus(mk_op(1'b0, 4'd0, 32'd0, 32'd0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int start;
    int sent;
    op_t o;

    rst = 1'b1;
    bus_if.req_valid = 1'b0;
    bus_if.req_fpu   = 1'b0;
    bus_if.req_ctrl  = 4'd0;
    bus_if.req_a     = 32'd0;
    bus_if.req_b     = 32'd0;
    bus_if.rsp_ready = 1'b0;

    // ---- reset state
    repeat (3) tick();
    check_all_zero("reset");
    chk_stats();
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 32'(bus_if.req_ready), 32'd1);

    // ---- directed single ops
    bus_if.rsp_ready = 1'b1;
    run_one(mk_op(1'b0, 4'd0, 32'd2, 32'd4));
    run_one(mk_op(1'b1, 4'd1, 32'hFFFF_FFFC, 32'd8));
    run_one(mk_op(1'b0, 4'd5, 32'd36, 32'd36));
    chk_stats();

    // ---- backpressure: hold one op in RESP, fill FIFO, stall, then drain
    bus_if.rsp_ready = 1'b0;
    drive_req(rand_op());
    bus_if.req_valid = 1'b1;
    step();
    n = 0;
    while (!bus_if.rsp_valid && n < 10) begin step(); n++; end
    chk("bp_in_resp", 32'(bus_if.rsp_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive_req(rand_op());
      bus_if.req_valid = 1'b1;
      chk("bp_fill_ready", 32'(bus_if.req_ready), 32'd1);
      step();
    end
    chk("bp_full_ready", 32'(bus_if.req_ready), 32'd0);
    drive_req(rand_op());
    bus_if.req_valid = 1'b1;
    step();
    step();
    chk("bp_stall_ready", 32'(bus_if.req_ready), 32'd0);
    bus_if.rsp_ready = 1'b1;
    chk_gap   = 1'b1;
    have_prev = 1'b0;
    start     = rsp_total;
    n = 0;
    while ((model_q.size() != 0 || bus_if.req_valid) && n < 60) begin step(); n++; end
    chk_gap = 1'b0;
    chk("bp_drain_count", 32'(rsp_total - start), 32'd6);
    chk("bp_drain_idle", 32'(bus_if.rsp_valid), 32'd0);
    chk_stats();

    // ---- randomized stream with random backpressure
    sent = 0;
    start = rsp_total;
    n = 0;
    while ((sent < 40 || bus_if.req_valid || model_q.size() != 0) && n < 3000) begin
      if (!bus_if.req_valid && sent < 40 && $urandom_range(0, 2) != 0) begin
        drive_req(rand_op());
        bus_if.req_valid = 1'b1;
        sent++;
      end
      bus_if.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    chk("rand_drained", 32'(model_q.size()), 32'd0);
    chk("rand_count", 32'(rsp_total - start), 32'd40);
    bus_if.rsp_ready = 1'b1;
    tick();
    chk_stats();

    // ---- reset while in RESP with two entries queued
    bus_if.rsp_ready = 1'b0;
    drive_req(rand_op());
    bus_if.req_valid = 1'b1;
    step();
    n = 0;
    while (!bus_if.rsp_valid && n < 10) begin step(); n++; end
    for (int i = 0; i < 2; i++) begin
      drive_req(rand_op());
      bus_if.req_valid = 1'b1;
      step();
    end
    chk("rst_pre_valid", 32'(bus_if.rsp_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_q.delete();
    exp_alu = 0;
    exp_fpu = 0;
    check_all_zero("midrst");
    chk_stats();
    bus_if.rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("midrst_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
    end

    // ---- 3 ALU + 2 FPU ops after reset (counter check when enabled)
    for (int i = 0; i < 5; i++) begin
      o = rand_op();
      o.fpu = (i >= 3);
      run_one(o);
    end
    chk_stats();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
